// File: rtl/fcvt_wb_stage.sv
// ---------------------------------------------------------------------------
// fcvt_wb_stage
//
// Writeback skid stage for the float-to-int converter. It holds a 2-entry
// FIFO of {integer result, destination tag, fflags}. When the flags feature
// is built in, it derives the IEEE exception flags from the original float
// operand at push time. It also keeps a sticky accumulator of the flags that
// have retired through the output handshake.
//
// Build option:
//   FCVT_WB_FLAGS_EN - when defined, the stage computes, stores and
//                      accumulates flags. When undefined, out_flags and
//                      fflags_acc are tied to zero and clear_flags is
//                      ignored.
//
// Parameters:
//   BUS_WIDTH - datapath width; 64 selects double format, 32 selects single.
//   RD_WIDTH  - destination-register tag width.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   converter result valid
//   in_ready    out  stage can accept an entry (registered occupancy only)
//   in_src      in   original IEEE-754 operand
//   in_int      in   converted signed integer, passed through unmodified
//   in_rd       in   destination register tag
//   out_valid   out  head entry valid
//   out_ready   in   writeback accepts the head entry
//   out_int     out  head entry integer
//   out_rd      out  head entry tag
//   out_flags   out  head entry fflags {NV,DZ,OF,UF,NX}
//   clear_flags in   clear the sticky accumulator (wins over a same-cycle pop)
//   fflags_acc  out  sticky OR of retired flags
// ---------------------------------------------------------------------------
module fcvt_wb_stage #(
    parameter int BUS_WIDTH = 64,
    parameter int RD_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_src,
    input  logic [BUS_WIDTH-1:0] in_int,
    input  logic [RD_WIDTH-1:0]  in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_int,
    output logic [RD_WIDTH-1:0]  out_rd,
    output logic [4:0]           out_flags,
    input  logic                 clear_flags,
    output logic [4:0]           fflags_acc
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic       push;
    logic       pop;

    logic [BUS_WIDTH-1:0] int_mem_q [2];
    logic [RD_WIDTH-1:0]  rd_mem_q  [2];

    // Ready depends only on registered occupancy, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage is not reset; contents are meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            int_mem_q[wr_ptr_q] <= in_int;
            rd_mem_q[wr_ptr_q]  <= in_rd;
        end
    end

    assign out_int = int_mem_q[rd_ptr_q];
    assign out_rd  = rd_mem_q[rd_ptr_q];

`ifdef FCVT_WB_FLAGS_EN
    localparam int EW   = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MS   = (BUS_WIDTH == 64) ? 52 : 23;
    localparam int BIAS = (BUS_WIDTH == 64) ? 1023 : 127;

    localparam logic signed [EW+1:0] BIAS_S   = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] MS_S     = (EW+2)'(MS);
    localparam logic signed [EW+1:0] NV_LIM_S = (EW+2)'(BUS_WIDTH - 1);
    // The only in-range value with e >= BUS_WIDTH-1 is exactly -2^(BUS_WIDTH-1).
    localparam logic [EW-1:0]        MIN_EXP  = EW'(BIAS + BUS_WIDTH - 1);
    localparam logic [BUS_WIDTH-1:0] MIN_INT_F = {1'b1, MIN_EXP, {MS{1'b0}}};

    function automatic logic [4:0] calc_flags(input logic [BUS_WIDTH-1:0] src);
        logic [EW-1:0]          ex;
        logic [MS-1:0]          man;
        logic [MS-1:0]          frac_mask;
        logic signed [EW+1:0]   e;
        logic                   nv;
        logic                   nx;
        ex  = src[BUS_WIDTH-2 -: EW];
        man = src[MS-1:0];
        e   = $signed({2'b00, ex}) - BIAS_S;
        nv  = (&ex) || ((e >= NV_LIM_S) && (src != MIN_INT_F));
        // For 0 <= e < MS the low (MS-e) mantissa bits are the fraction.
        frac_mask = {MS{1'b1}} >> e[EW-1:0];
        nx  = !nv && (src[BUS_WIDTH-2:0] != '0) &&
              (e[EW+1] || ((e < MS_S) && (|(man & frac_mask))));
        return {nv, 3'b000, nx};
    endfunction

    logic [4:0] flg_mem_q [2];
    logic [4:0] acc_q;

    always_ff @(posedge clk) begin
        if (push) flg_mem_q[wr_ptr_q] <= calc_flags(in_src);
    end

    assign out_flags = flg_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 5'b0;
        end else if (clear_flags) begin
            acc_q <= 5'b0;
        end else if (pop) begin
            acc_q <= acc_q | out_flags;
        end
    end

    assign fflags_acc = acc_q;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_src, clear_flags};
    assign out_flags  = 5'b0;
    assign fflags_acc = 5'b0;
`endif

endmodule

// File: doc/fcvt_wb_stage.md
FCVT_WB_STAGE -- requirements
Module: fcvt_wb_stage

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, meaning datapath width; 64 selects double format, 32 selects single format.
REQ-002 SHALL have parameter RD_WIDTH, default 5, meaning destination-register tag width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream converter result valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port in_src  input  BUS_WIDTH  original IEEE-754 float operand given to the float-to-int converter.
REQ-008 SHALL have port in_int  input  BUS_WIDTH  signed integer produced by the float-to-int converter.
REQ-009 SHALL have port in_rd  input  RD_WIDTH  destination register tag.
REQ-010 SHALL have port out_valid  output  1  writeback entry valid.
REQ-011 SHALL have port out_ready  input  1  writeback accepts entry.
REQ-012 SHALL have port out_int, out_rd, out_flags  output  BUS_WIDTH, RD_WIDTH, 5  head entry data and per-op fflags {NV,DZ,OF,UF,NX}.
REQ-013 SHALL have port clear_flags  input  1  clear sticky accumulator.
REQ-014 SHALL have port fflags_acc  output  5  sticky OR of all flags retired through out handshake.

Function
REQ-015 SHALL implement a 2-entry FIFO of {int, rd, flags}; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-016 SHALL drive in_ready = (count < 2) from registered count only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0); latency from push to out_valid is exactly 1 cycle.
REQ-018 SHALL leave count unchanged on simultaneous push and pop with count = 1; push is impossible at count = 2.
REQ-019 SHALL advance read/write pointers as 1-bit wrapping indices.
REQ-020 SHALL hold out_int/out_rd/out_flags stable while out_valid & ~out_ready.
REQ-021 SHALL compute flags from in_src at push. E is the exponent field, M the mantissa field, MS = 52/23, BIAS = 1023/127, e = E - BIAS as signed.
REQ-022 SHALL set NV when E is all ones (NaN or infinity), or when e >= BUS_WIDTH-1 unless in_src is exactly -2^(BUS_WIDTH-1).
REQ-023 SHALL set NX when NV = 0, {E,M} != 0 and either e < 0, or 0 <= e < MS with the low (MS-e) bits of M nonzero.
REQ-024 SHALL hold DZ, OF and UF at 0 always.
REQ-025 SHALL OR the popped entry's out_flags into fflags_acc on pop; clear_flags zeroes it and has priority over a same-cycle pop.
REQ-026 SHALL pass in_int unmodified; saturation is owned by the converter.

Reset
REQ-027 SHALL force count = 0, both pointers = 0, out_valid = 0, in_ready = 1 and fflags_acc = 0 while rst_n = 0 at a clock edge.
REQ-028 SHALL discard all buffered entries if reset is asserted mid-operation; no pop occurs in that cycle.
REQ-029 SHALL not reset FIFO data storage; out_int, out_rd and out_flags are don't-care while out_valid = 0.

Configuration
REQ-030 SHALL, with FCVT_WB_FLAGS_EN defined, implement REQ-021..REQ-025 as written.
REQ-031 SHALL, without FCVT_WB_FLAGS_EN, store no flag bits and tie out_flags and fflags_acc to 5'b0; clear_flags is ignored.

Verification
REQ-032 SHALL cover: BUS_WIDTH=64, push in_src=0x4009000000000000 (3.125), in_int=3 -> next cycle out_valid=1, out_int=3, out_flags=5'b00001.
REQ-033 SHALL cover: push in_src=0x7FF8000000000000 (NaN) -> out_flags=5'b10000; after pop, fflags_acc=5'b10000.
REQ-034 SHALL cover: push in_src=0xC3E0000000000000 (-2^63) -> out_flags=0; push 0x43E0000000000000 (+2^63) -> out_flags=5'b10000.
REQ-035 SHALL cover: out_ready=0, three back-to-back pushes -> third cycle in_ready=0, only two entries stored, FIFO order preserved on drain.
REQ-036 SHALL cover: count=1 with push and pop in the same cycle -> count stays 1, out_int updates to the new entry next cycle.
REQ-037 SHALL cover: two entries buffered, rst_n=0 for one edge -> out_valid=0, in_ready=1, fflags_acc=0.
